// File: rtl/viterbi_encode9.sv
// viterbi_encode9
//   Rate-1/2, K=9 convolutional encoder with generators G1 (y[1]) and G0
//   (y[0]). One information bit enters per clock. One registered 2-bit symbol
//   leaves per clock.
//
// Ports
//   x      in   1  information bit, sampled on every rising clk edge
//   y      out  2  coded symbol {y[1], y[0]}, registered
//   clk    in   1  system clock
//   reset  in   1  asynchronous reset, active low; clears history and y
//
// Tap convention: bit k of a generator multiplies the input from k cycles
// ago. Bit 0 is the current input x. The octal patterns are used as written,
// with no bit reversal.
module viterbi_encode9 #(
  parameter logic [8:0] G1 = 9'o753,
  parameter logic [8:0] G0 = 9'o561
) (
  input  logic       x,
  output logic [1:0] y,
  input  logic       clk,
  input  logic       reset
);

  // Past inputs: hist_p0[0] is the previous bit, hist_p0[7] is 8 cycles old.
  logic [7:0] hist_p0;
  logic [8:0] v;

  function automatic logic parity9(input logic [8:0] a);
    return ^a;
  endfunction

  assign v = {hist_p0, x};

  // Stage 0 -> output: encode the current window and register the symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_p0 <= '0;
      y       <= 2'b00;
    end else begin
      y       <= {parity9(v & G1), parity9(v & G0)};
      hist_p0 <= {hist_p0[6:0], x};
    end
  end

endmodule

// File: tb/tb_viterbi_encode9.sv
module tb_viterbi_encode9;

  logic       clk;
  logic       reset;
  logic       x;
  logic [1:0] y;

  int errors = 0;
  int checks = 0;

  // Generators written out independently of the design defaults.
  localparam logic [8:0] REF_G1 = 9'o753;
  localparam logic [8:0] REF_G0 = 9'o561;

  // Reference history: hist[0] is the newest bit that has been clocked in.
  bit hist[$];

  viterbi_encode9 dut (
    .x    (x),
    .y    (y),
    .clk  (clk),
    .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Golden encoder: each output is the mod-2 sum of the generator-weighted
  // inputs over the last 9 bits. Bits older than the history count as zero.
  function automatic logic [1:0] model();
    int s1 = 0;
    int s0 = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < hist.size()) begin
        s1 += int'(hist[k]) * int'(REF_G1[k]);
        s0 += int'(hist[k]) * int'(REF_G0[k]);
      end
    end
    return {1'(s1 % 2), 1'(s0 % 2)};
  endfunction

  // Called away from the clock edge. It drives the bit, takes one edge and
  // samples 1 time unit later.
  task automatic step(input logic b, input string tag);
    x = b;
    @(posedge clk);
    hist.push_front(b);
    #1;
    check(tag, y, model());
  endtask

  // Holds reset through one edge with x=1, checks y=00, then releases.
  task automatic do_reset();
    reset = 1'b0;
    x = 1'b1;
    hist.delete();
    @(posedge clk);
    #1;
    check("reset_hold", y, 2'b00);
    reset = 1'b1;
  endtask

  logic [1:0] seq_exp [5] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b00};
  logic       seq_in  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] imp_exp [9] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b01,
                              2'b11, 2'b11, 2'b10, 2'b11};

  initial begin
    reset = 1'b0;
    x = 1'b1;
    #2;
    check("reset_async_init", y, 2'b00);

    // Short directed sequence 1,0,0,1,1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(seq_in[i], "seq_model");
      check("seq_table", y, seq_exp[i]);
    end

    // Impulse response followed by zeros
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step((i == 0) ? 1'b1 : 1'b0, "impulse_model");
      check("impulse_table", y, (i < 9) ? imp_exp[i] : 2'b00);
    end

    // All ones for 12 cycles; from the 9th edge on, y stays at 11
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, "ones_model");
      if (i >= 8) check("ones_steady", y, 2'b11);
    end

    // Reset asserted between edges drops y with no clock edge
    do_reset();
    step(1'b1, "async_pre0");
    step(1'b0, "async_pre1");
    #1;
    reset = 1'b0;
    #1;
    check("async_drop", y, 2'b00);
    hist.delete();
    reset = 1'b1;
    step(1'b1, "async_cold_model");
    check("async_cold_table", y, 2'b11);

    // All zeros
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, "zeros_model");
      check("zeros_table", y, 2'b00);
    end

    // Random 1000-bit stream against the golden encoder
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
